// File: rtl/lcd_bus_responder.sv
// -----------------------------------------------------------------------------
// lcd_bus_responder
//
// Panel side of an HD44780-style character-LCD bus. Decodes instruction and
// data writes into an internal DDRAM and answers status and data reads.
// Intended as an on-chip LCD model for controller bring-up and as a bus
// target in system simulation.
//
// Parameters
//   DDRAM_DEPTH   DDRAM size in bytes (address counter is 7 bits, <= 128)
//   BUSY_CYCLES   busy time after a data write or an ordinary instruction
//   CLEAR_CYCLES  busy time after clear/return-home (>= DDRAM_DEPTH, so the
//                 clear sweep always finishes inside the busy window)
//
// Ports
//   clk          clock; every bus input is synchronous to it
//   rst          synchronous reset, active-high
//   lcd_rs       register select: 0 = instruction/status, 1 = data
//   lcd_rw       0 = write, 1 = read
//   lcd_en       enable; a transfer completes on its falling edge
//   lcd_data_i   write data from the controller
//   lcd_data_o   read data to the controller (0 when not driving)
//   lcd_data_oe  drive enable for lcd_data_o
//   busy         busy flag (also bit 7 of a status read)
//   ddram_addr   current address counter
//   cmd_err      one-cycle pulse on a rejected or illegal transfer
//
// Optional feature (macro LCD_RESP_SCAN_PORT_EN)
//   Adds scan_addr (in, 7) and scan_data (out, 8): a side read port that
//   returns mem[scan_addr] one cycle later, 0x00 for addresses beyond the
//   DDRAM. It ignores bus traffic; a same-cycle bus write returns the old byte.
//
// Bus handshake
//   rs/rw/data are captured on every cycle lcd_en is high. The transfer
//   completes at the strobe (lcd_en registered high, now low) and acts on the
//   values captured in the last en-high cycle. A strobe is accepted only when
//   the busy counter is zero in the strobe cycle itself; the resulting
//   ddram_addr/busy change is visible in the following cycle.
// -----------------------------------------------------------------------------
module lcd_bus_responder #(
  parameter int DDRAM_DEPTH  = 80,
  parameter int BUSY_CYCLES  = 37,
  parameter int CLEAR_CYCLES = 1520
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data_i,
  output logic [7:0] lcd_data_o,
  output logic       lcd_data_oe,
  output logic       busy,
  output logic [6:0] ddram_addr,
  output logic       cmd_err
`ifdef LCD_RESP_SCAN_PORT_EN
  ,
  input  logic [6:0] scan_addr,
  output logic [7:0] scan_data
`endif
);

  // Counter must hold the longest busy load.
  localparam int CMAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] LD_BUSY   = CW'(BUSY_CYCLES);
  localparam logic [CW-1:0] LD_CLEAR  = CW'(CLEAR_CYCLES);
  localparam logic [CW-1:0] LD_RESET  = CW'(DDRAM_DEPTH);
  localparam logic [7:0]    DEPTH8    = 8'(DDRAM_DEPTH);
  localparam logic [6:0]    LAST_ADDR = 7'(DDRAM_DEPTH - 1);
  localparam logic [7:0]    BLANK     = 8'h20;

  // IDLE: no command in flight. EXEC: the cycle in which an accepted
  // command's effects (address, memory, busy load) first become visible.
  // WAIT: busy counter running down.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t        state;

  // Bus capture
  logic          en_q;
  logic          cap_rs;
  logic          cap_rw;
  logic [7:0]    cap_d;

  // Core state
  logic [CW-1:0] count;
  logic [6:0]    addr;
  logic          id;          // 1 = increment, 0 = decrement
  logic          sweep_on;    // blank-fill of DDRAM in progress
  logic [6:0]    sweep_ptr;
  logic          oe_q;
  logic [7:0]    rd_q;
  logic          err_q;

  logic [7:0]    mem [DDRAM_DEPTH];

  // Decode results
  logic          strobe;
  logic          busy_now;
  logic [6:0]    addr_step;
  logic [6:0]    nxt_addr;
  logic          nxt_id;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          sweep_go;
  logic          mem_we;
  logic          err_nxt;
  logic          exec_go;

  assign strobe   = en_q & ~lcd_en;
  assign busy_now = (count != '0);

  // Address counter step with wrap in both directions.
  always_comb begin
    addr_step = addr;
    if (id) begin
      addr_step = (addr == LAST_ADDR) ? 7'd0 : addr + 7'd1;
    end else begin
      addr_step = (addr == 7'd0) ? LAST_ADDR : addr - 7'd1;
    end
  end

  // Transfer decode. Instruction writes are classified by their highest set
  // bit; a status read strobe is accepted silently and changes nothing.
  always_comb begin
    nxt_addr = addr;
    nxt_id   = id;
    cnt_load = 1'b0;
    cnt_val  = '0;
    sweep_go = 1'b0;
    mem_we   = 1'b0;
    err_nxt  = 1'b0;
    exec_go  = 1'b0;
    if (strobe) begin
      if (busy_now) begin
        // Writes and data reads are rejected while busy; status reads are not.
        err_nxt = ~cap_rw | cap_rs;
      end else if (!cap_rw) begin
        exec_go = 1'b1;
        if (cap_rs) begin
          mem_we   = 1'b1;
          nxt_addr = addr_step;
          cnt_load = 1'b1;
          cnt_val  = LD_BUSY;
        end else begin
          casez (cap_d)
            8'b1???_????: begin
              cnt_load = 1'b1;
              cnt_val  = LD_BUSY;
              if ({1'b0, cap_d[6:0]} >= DEPTH8) begin
                nxt_addr = 7'd0;
                err_nxt  = 1'b1;
              end else begin
                nxt_addr = cap_d[6:0];
              end
            end
            8'b0000_0001: begin
              nxt_addr = 7'd0;
              nxt_id   = 1'b1;
              sweep_go = 1'b1;
              cnt_load = 1'b1;
              cnt_val  = LD_CLEAR;
            end
            8'b0000_001?: begin
              nxt_addr = 7'd0;
              cnt_load = 1'b1;
              cnt_val  = LD_CLEAR;
            end
            8'b0000_01??: begin
              nxt_id   = cap_d[1];
              cnt_load = 1'b1;
              cnt_val  = LD_BUSY;
            end
            8'b0000_0000: begin
              // no-op: no busy period
              cnt_load = 1'b0;
            end
            default: begin
              cnt_load = 1'b1;
              cnt_val  = LD_BUSY;
            end
          endcase
        end
      end else if (cap_rs) begin
        // Accepted data read: post-step the address, no busy period.
        exec_go  = 1'b1;
        nxt_addr = addr_step;
      end
    end
  end

  // Control state, bus capture and registered read path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_WAIT;
      en_q      <= 1'b0;
      cap_rs    <= 1'b0;
      cap_rw    <= 1'b0;
      cap_d     <= 8'h00;
      count     <= LD_RESET;
      addr      <= 7'd0;
      id        <= 1'b1;
      sweep_on  <= 1'b1;
      sweep_ptr <= 7'd0;
      oe_q      <= 1'b0;
      rd_q      <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      en_q <= lcd_en;
      if (lcd_en) begin
        cap_rs <= lcd_rs;
        cap_rw <= lcd_rw;
        cap_d  <= lcd_data_i;
      end

      oe_q  <= lcd_en & lcd_rw;
      rd_q  <= busy_now ? 8'h00 : mem[addr];
      err_q <= err_nxt;

      addr <= nxt_addr;
      id   <= nxt_id;

      // A load only happens on an accepted strobe, i.e. with count at zero,
      // so it never competes with the decrement.
      if (cnt_load) begin
        count <= cnt_val;
      end else if (busy_now) begin
        count <= count - CW'(1);
      end

      if (sweep_go) begin
        sweep_on  <= 1'b1;
        sweep_ptr <= 7'd0;
      end else if (sweep_on) begin
        if (sweep_ptr == LAST_ADDR) begin
          sweep_on <= 1'b0;
        end
        sweep_ptr <= sweep_ptr + 7'd1;
      end

      case (state)
        ST_IDLE: begin
          if (exec_go) state <= ST_EXEC;
        end
        ST_EXEC: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (exec_go) begin
            state <= ST_EXEC;
          end else if (!busy_now) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // DDRAM write port. The sweep only runs while busy and bus writes are only
  // accepted while not busy, so the two sources never collide.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sweep_on) begin
        mem[sweep_ptr] <= BLANK;
      end else if (mem_we) begin
        mem[addr] <= cap_d;
      end
    end
  end

`ifdef LCD_RESP_SCAN_PORT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_data <= 8'h00;
    end else if ({1'b0, scan_addr} < DEPTH8) begin
      scan_data <= mem[scan_addr];
    end else begin
      scan_data <= 8'h00;
    end
  end
`else
  // Without the scan port the DDRAM is visible only through bus data reads.
`endif

  // Status reads are live; data reads come from the registered read path.
  assign lcd_data_o  = oe_q ? (cap_rs ? rd_q : {busy_now, addr}) : 8'h00;
  assign lcd_data_oe = oe_q;
  assign busy        = busy_now;
  assign ddram_addr  = addr;
  assign cmd_err     = err_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
module tb_lcd_bus_responder;

  localparam int DEPTH = 80;
  localparam int BUSYC = 37;
  localparam int CLRC  = 1520;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic       lcd_en = 1'b0;
  logic [7:0] lcd_data_i = 8'h00;
  logic [7:0] lcd_data_o;
  logic       lcd_data_oe;
  logic       busy;
  logic [6:0] ddram_addr;
  logic       cmd_err;
`ifdef LCD_RESP_SCAN_PORT_EN
  logic [6:0] scan_addr = 7'd0;
  logic [7:0] scan_data;
`endif

  always #5 clk = ~clk;

  lcd_bus_responder dut (
    .clk         (clk),
    .rst         (rst),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_en      (lcd_en),
    .lcd_data_i  (lcd_data_i),
    .lcd_data_o  (lcd_data_o),
    .lcd_data_oe (lcd_data_oe),
    .busy        (busy),
    .ddram_addr  (ddram_addr),
    .cmd_err     (cmd_err)
`ifdef LCD_RESP_SCAN_PORT_EN
    ,
    .scan_addr   (scan_addr),
    .scan_data   (scan_data)
`endif
  );

  // ---------------------------------------------------------------------------
  // Reference model: panel state plus the cycle at which busy ends
  // ---------------------------------------------------------------------------
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] m_mem [DEPTH];
  int         m_addr = 0;
  bit         m_id = 1'b1;
  int         busy_end = 0;
  int         err_at = -10;
  bit         valid = 1'b0;
  logic [7:0] exp_q [$];
  logic       prev_rd = 1'b0;
  logic       prev_status = 1'b0;
  bit         exp_b;
  int         exp_status;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    prev_rd     <= lcd_en & lcd_rw;
    prev_status <= lcd_en & lcd_rw & ~lcd_rs;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int stepped(input int a, input bit inc);
    return (a + (inc ? 1 : DEPTH - 1)) % DEPTH;
  endfunction

  task automatic fill_model(input logic [7:0] v);
    for (int i = 0; i < DEPTH; i++) m_mem[i] = v;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard compare, every cycle once the model is valid
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (valid && !rst) begin
      exp_b      = (cyc < busy_end);
      exp_status = (exp_b ? 128 : 0) + m_addr;
      chk("busy", int'(busy), int'(exp_b));
      chk("ddram_addr", int'(ddram_addr), m_addr);
      chk("cmd_err", int'(cmd_err), (cyc == err_at) ? 1 : 0);
      chk("data_oe", int'(lcd_data_oe), int'(prev_rd));
      if (!prev_rd) begin
        chk("data_idle", int'(lcd_data_o), 0);
      end else if (prev_status) begin
        chk("status_live", int'(lcd_data_o), exp_status);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all start and end 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) sync();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cyc < busy_end && n < 5000) begin
      sync();
      n++;
    end
  endtask

  task automatic do_reset(input int n);
    valid  = 1'b0;
    rst    = 1'b1;
    lcd_en = 1'b0;
    lcd_rw = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst      = 1'b0;
    busy_end = cyc + DEPTH;
    m_addr   = 0;
    m_id     = 1'b1;
    err_at   = -10;
    fill_model(8'h20);
    valid    = 1'b1;
  endtask

  task automatic bus_write(input bit rs, input logic [7:0] d, input int hold);
    int s;
    bit bz;
    lcd_rs     = rs;
    lcd_rw     = 1'b0;
    lcd_data_i = d;
    lcd_en     = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    lcd_en     = 1'b0;
    s          = cyc;
    lcd_data_i = 8'($urandom);
    sync();
    bz = (s < busy_end);
    if (bz) begin
      err_at = s + 1;
    end else if (rs) begin
      m_mem[m_addr] = d;
      m_addr        = stepped(m_addr, m_id);
      busy_end      = s + 1 + BUSYC;
    end else if (d >= 8'h80) begin
      if (int'(d) - 128 >= DEPTH) begin
        m_addr = 0;
        err_at = s + 1;
      end else begin
        m_addr = int'(d) - 128;
      end
      busy_end = s + 1 + BUSYC;
    end else if (d == 8'h01) begin
      m_addr   = 0;
      m_id     = 1'b1;
      fill_model(8'h20);
      busy_end = s + 1 + CLRC;
    end else if (d == 8'h02 || d == 8'h03) begin
      m_addr   = 0;
      busy_end = s + 1 + CLRC;
    end else if (d >= 8'h04 && d <= 8'h07) begin
      m_id     = (d == 8'h06 || d == 8'h07);
      busy_end = s + 1 + BUSYC;
    end else if (d != 8'h00) begin
      busy_end = s + 1 + BUSYC;
    end
  endtask

  task automatic bus_read(input bit rs, input int hold, output logic [7:0] val);
    int s;
    lcd_rs = rs;
    lcd_rw = 1'b1;
    lcd_en = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    lcd_en = 1'b0;
    s      = cyc;
    if (rs) exp_q.push_back((s - 1 < busy_end) ? 8'h00 : m_mem[m_addr]);
    @(negedge clk);
    val = lcd_data_o;
    if (rs) chk("read_data", int'(val), int'(exp_q.pop_front()));
    sync();
    lcd_rw = 1'b0;
    if (rs) begin
      if (s < busy_end) err_at = s + 1;
      else m_addr = stepped(m_addr, m_id);
    end
  endtask

  function automatic int hold_len();
    return int'($urandom_range(1, 3));
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] v;
    int         n;
    int         r;
    int         nbad;

    // Reset: busy for exactly DDRAM_DEPTH cycles, blank DDRAM
    do_reset(3);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    chk("reset_busy_cycles", n, 80);
    sync();
    wait_idle();
    bus_read(1'b0, 1, v);
    chk("status_after_reset", int'(v), 8'h00);
    bus_read(1'b1, 1, v);
    chk("read0_after_reset", int'(v), 8'h20);

    // Write "HI" from address 0, then read it back
    bus_write(1'b0, 8'h80, 1); wait_idle();
    bus_write(1'b1, 8'h48, 2); wait_idle();
    bus_write(1'b1, 8'h49, 1);
    chk("addr_after_two_writes", int'(ddram_addr), 2);
    wait_idle();
    bus_write(1'b0, 8'h80, 1); wait_idle();
    bus_read(1'b1, 2, v);
    chk("read_H", int'(v), 8'h48);
    bus_read(1'b1, 1, v);
    chk("read_I", int'(v), 8'h49);

    // Decrement mode and wrap at both ends
    wait_idle();
    bus_write(1'b0, 8'h04, 1); wait_idle();
    bus_write(1'b0, 8'h80, 1); wait_idle();
    bus_write(1'b1, 8'h41, 1);
    chk("dec_wrap_0_to_79", int'(ddram_addr), 79);
    wait_idle();
    bus_write(1'b1, 8'h42, 1);
    chk("dec_from_79", int'(ddram_addr), 78);
    wait_idle();
    bus_write(1'b0, 8'h06, 1); wait_idle();

    // Writes during the busy window are rejected
    bus_write(1'b1, 8'h55, 1);
    bus_write(1'b1, 8'h66, 1);
    chk("busy_write_err", int'(cmd_err), 1);
    chk("busy_write_addr", int'(ddram_addr), 79);
    bus_read(1'b0, 1, v);
    chk("busy_status_bit7", int'(v[7]), 1);
    wait_idle();
    bus_write(1'b0, 8'hCF, 1); wait_idle();
    bus_read(1'b1, 1, v);
    chk("rejected_write_no_mem", int'(v), 8'h42);

    // Randomized traffic
    for (int k = 0; k < 250; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 30)      bus_write(1'b1, 8'($urandom), hold_len());
      else if (r < 45) bus_read(1'b1, hold_len(), v);
      else if (r < 55) bus_read(1'b0, hold_len(), v);
      else if (r < 70) bus_write(1'b0, 8'h80 | 8'($urandom_range(0, 127)), hold_len());
      else if (r < 78) bus_write(1'b0, 8'($urandom_range(4, 7)), hold_len());
      else if (r < 85) bus_write(1'b0, 8'($urandom_range(8, 127)), hold_len());
      else if (r < 88) bus_write(1'b0, 8'h00, hold_len());
      else if (r < 89) bus_write(1'b0, 8'($urandom_range(2, 3)), hold_len());
      else if (r < 90) bus_write(1'b0, 8'h01, hold_len());
      else             idle(1);
      if ($urandom_range(0, 99) < 60) idle(int'($urandom_range(0, 45)));
      else wait_idle();
    end

    // Fill DDRAM, then clear from decrement mode
    wait_idle();
    bus_write(1'b0, 8'h06, 1); wait_idle();
    bus_write(1'b0, 8'h80, 1); wait_idle();
    for (int i = 0; i < DEPTH; i++) begin
      bus_write(1'b1, 8'($urandom_range(0, 255)), 1);
      wait_idle();
    end
    bus_write(1'b0, 8'h04, 1); wait_idle();
    bus_write(1'b0, 8'h01, 1);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    chk("clear_busy_cycles", n, 1520);
    sync();
    nbad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(1'b1, 1, v);
      if (v != 8'h20) nbad++;
    end
    chk("clear_all_blank", nbad, 0);
    chk("addr_after_80_reads", int'(ddram_addr), 0);
    bus_write(1'b1, 8'h33, 1);
    chk("clear_sets_increment", int'(ddram_addr), 1);

    // Out-of-range set-address
    wait_idle();
    bus_write(1'b0, 8'h85, 1); wait_idle();
    bus_write(1'b0, 8'hD0, 1);
    chk("bad_addr_zero", int'(ddram_addr), 0);
    chk("bad_addr_err", int'(cmd_err), 1);

    // Reset in the middle of a clear
    wait_idle();
    bus_write(1'b0, 8'h80, 1); wait_idle();
    bus_write(1'b1, 8'h77, 1); wait_idle();
    bus_write(1'b0, 8'h01, 1);
    idle(300);
    do_reset(2);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    chk("rst_mid_clear_busy", n, 80);
    sync();
    wait_idle();
    bus_read(1'b1, 1, v);
    chk("rst_mid_clear_byte", int'(v), 8'h20);
    bus_read(1'b0, 1, v);
    chk("rst_mid_clear_status", int'(v), 8'h01);

    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
